mem_access_unit: RTL

Parametrised memory-access stage for the MIPS pipeline. It drives the SRAM-like data bus (req/addr_ok/data_ok) with up to MAX_OUTSTANDING requests in flight, and checks alignment before issue. It aligns store data and extracts and sign-extends load data. Sits between the EX/MEM register and writeback; generates a pipeline stall and supports a flush that discards in-flight results while still draining the bus.

---
 rtl/mem_access_unit.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MIPS MEM stage: SRAM-like data bus master with in-order tag FIFO
// Optional MEM_PERF_EN adds perf_loads / perf_stores / perf_wait_cycles counters.
module mem_access_unit #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int TAG_AW          = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_memreq,
  input  logic        in_wr,
  input  logic [1:0]  in_size,
  input  logic        in_sign,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic        flush,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        out_valid,
  output logic [31:0] out_rdata,
  output logic [1:0]  out_addr_err,
  output logic [31:0] out_badvaddr,
  output logic        stall
`ifdef MEM_PERF_EN
  ,
  output logic [31:0] perf_loads,
  output logic [31:0] perf_stores,
  output logic [31:0] perf_wait_cycles
`endif
);

  localparam int DEPTH = 1 << TAG_AW;
  localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

  logic [3:0]        count;
  logic [TAG_AW-1:0] wr_ptr;
  logic [TAG_AW-1:0] rd_ptr;

  logic              tag_wr   [DEPTH];
  logic [1:0]        tag_size [DEPTH];
  logic              tag_sign [DEPTH];
  logic [1:0]        tag_off  [DEPTH];
  logic              tag_live [DEPTH];

  logic        misaligned;
  logic        bus_op;
  logic        local_ok;
  logic        local_acc;
  logic        push;
  logic        pop;
  logic        head_live;
  logic [31:0] shifted;
  logic [31:0] load_ext;

  always_comb begin
    misaligned = ((in_size == 2'd1) & in_addr[0]) |
                 ((in_size == 2'd2) & (in_addr[1:0] != 2'b00));
    bus_op     = in_memreq & ~misaligned;
    // Non-bus ops wait for an empty FIFO so completions stay in program order.
    local_ok   = (count == 4'd0) & ~flush;
    data_req   = in_valid & bus_op & ~flush & (count < MAX_CNT);
    in_ready   = bus_op ? (data_req & data_addr_ok) : local_ok;
    stall      = in_valid & ~in_ready;
    local_acc  = in_valid & ~bus_op & local_ok;
    push       = data_req & data_addr_ok;
    pop        = data_data_ok & (count != 4'd0);
    head_live  = tag_live[rd_ptr] & ~flush;
  end

  always_comb begin
    data_wr   = in_wr;
    data_size = in_size;
    data_addr = in_addr;
    case (in_size)
      2'd0:    data_wdata = {4{in_wdata[7:0]}};
      2'd1:    data_wdata = {2{in_wdata[15:0]}};
      default: data_wdata = in_wdata;
    endcase
  end

  always_comb begin
    shifted = data_rdata >> {tag_off[rd_ptr], 3'b000};
    case (tag_size[rd_ptr])
      2'd0:    load_ext = {{24{tag_sign[rd_ptr] & shifted[7]}}, shifted[7:0]};
      2'd1:    load_ext = {{16{tag_sign[rd_ptr] & shifted[15]}}, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= 4'd0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_wr[i]   <= 1'b0;
        tag_size[i] <= 2'd0;
        tag_sign[i] <= 1'b0;
        tag_off[i]  <= 2'd0;
        tag_live[i] <= 1'b0;
      end
    end else begin
      // Flush kills every queued tag; the responses still drain the FIFO.
      if (flush) begin
        for (int i = 0; i < DEPTH; i++) tag_live[i] <= 1'b0;
      end
      if (push) begin
        tag_wr[wr_ptr]   <= in_wr;
        tag_size[wr_ptr] <= in_size;
        tag_sign[wr_ptr] <= in_sign;
        tag_off[wr_ptr]  <= in_addr[1:0];
        tag_live[wr_ptr] <= 1'b1;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {3'b000, push} - {3'b000, pop};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_rdata    <= 32'd0;
      out_addr_err <= 2'b00;
      out_badvaddr <= 32'd0;
    end else if (local_acc) begin
      out_valid    <= 1'b1;
      out_rdata    <= 32'd0;
      out_addr_err <= (in_memreq & misaligned) ? (in_wr ? 2'b10 : 2'b01) : 2'b00;
      out_badvaddr <= (in_memreq & misaligned) ? in_addr : 32'd0;
    end else if (pop & head_live) begin
      out_valid    <= 1'b1;
      out_rdata    <= tag_wr[rd_ptr] ? 32'd0 : load_ext;
      out_addr_err <= 2'b00;
      out_badvaddr <= 32'd0;
    end else begin
      out_valid    <= 1'b0;
      out_rdata    <= 32'd0;
      out_addr_err <= 2'b00;
      out_badvaddr <= 32'd0;
    end
  end

`ifdef MEM_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_loads       <= 32'd0;
      perf_stores      <= 32'd0;
      perf_wait_cycles <= 32'd0;
    end else begin
      if (pop & head_live & ~tag_wr[rd_ptr]) perf_loads <= perf_loads + 32'd1;
      if (pop & head_live & tag_wr[rd_ptr])  perf_stores <= perf_stores + 32'd1;
      if ((count != 4'd0) & ~data_data_ok)   perf_wait_cycles <= perf_wait_cycles + 32'd1;
    end
  end
`endif

endmodule
